// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes and flags.
// Optional barrel shifter on logic codes 011/010/001 when ALU_SHIFT_EN is defined.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   in_valid/in_ready   input handshake; status, opcode, a, b captured on transfer
//   out_valid/out_ready output handshake; out + cout/overflow/zero/negative/illegal
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             status,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             negative,
  output logic             illegal
);

  typedef struct packed {
    logic             status;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } s1_t;

  typedef struct packed {
    logic [WIDTH-1:0] out;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             neg;
    logic             ill;
  } res_t;

  logic s1_valid;
  s1_t  s1;
  res_t res;
  logic s2_adv;
  logic s1_adv;

  assign s2_adv   = !out_valid | out_ready;
  assign s1_adv   = s2_adv | !s1_valid;
  assign in_ready = s1_adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid)
        s1 <= '{status, opcode, a, b};
    end
  end

  // INC/DEC reuse the adder with a constant 1 in place of b;
  // opcode[0]=0 selects subtract, whose top bit is the borrow.
  logic [WIDTH-1:0] rhs;
  logic             sub;
  logic [WIDTH:0]   sum;
  logic             ovf;

  always_comb begin
    rhs = s1.opcode[1] ? s1.b : {{(WIDTH-1){1'b0}}, 1'b1};
    sub = ~s1.opcode[0];
    if (sub)
      sum = {1'b0, s1.a} - {1'b0, rhs};
    else
      sum = {1'b0, s1.a} + {1'b0, rhs};
    ovf = (s1.a[WIDTH-1] == (rhs[WIDTH-1] ^ sub))
        & (sum[WIDTH-1] != s1.a[WIDTH-1]);
  end

`ifdef ALU_SHIFT_EN
  localparam int SHW = $clog2(WIDTH);

  // One spare bit on each side catches the last bit shifted out.
  logic [SHW-1:0] sh;
  logic [WIDTH:0] shl_w;
  logic [WIDTH:0] shr_w;
  logic [WIDTH:0] sra_w;

  always_comb begin
    sh    = s1.b[SHW-1:0];
    shl_w = {1'b0, s1.a} << sh;
    shr_w = {s1.a, 1'b0} >> sh;
    sra_w = $signed({s1.a, 1'b0}) >>> sh;
  end
`endif

  always_comb begin
    res = '0;
    if (s1.status) begin
      if (s1.opcode[3]) begin
        if (s1.opcode[2]) begin
          res.out  = sum[WIDTH-1:0];
          res.cout = sum[WIDTH];
          res.ovf  = ovf;
        end else begin
          res.ill = 1'b1;
        end
      end else begin
        unique case (s1.opcode[2:0])
          3'b111: res.out = s1.a & s1.b;
          3'b110: res.out = s1.a | s1.b;
          3'b101: res.out = s1.a ^ s1.b;
          3'b100: res.out = ~s1.a;
`ifdef ALU_SHIFT_EN
          3'b011: begin
            res.out  = shl_w[WIDTH-1:0];
            res.cout = shl_w[WIDTH];
          end
          3'b010: begin
            res.out  = shr_w[WIDTH:1];
            res.cout = shr_w[0];
          end
          3'b001: begin
            res.out  = sra_w[WIDTH:1];
            res.cout = sra_w[0];
          end
`endif
          default: res.ill = 1'b1;
        endcase
      end
    end
    res.zero = (res.out == '0);
    res.neg  = res.out[WIDTH-1];
  end

  // zero/negative are registered alongside out so reset clears them too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      illegal   <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out      <= res.out;
        cout     <= res.cout;
        overflow <= res.ovf;
        zero     <= res.zero;
        negative <= res.neg;
        illegal  <= res.ill;
      end
    end
  end

endmodule
